// File: rtl/fft_controller.sv
// 16-point real-input FFT controller.
// Iterative radix-2 decimation-in-time over an internal complex register array,
// one butterfly per clock, Q1.15 twiddles, unscaled 32-bit wrap-around datapath.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start_fft; outputs hold the last completed result
//   COMPUTE | 32 butterflies, one per clock (4 stages x 8)
//   DONE    | publish the array to the outputs, raise fft_data_valid
module fft_controller #(
    parameter int FFT_POINTS = 16,
    parameter int DATA_WIDTH = 24,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_fft,
    input  logic [DATA_WIDTH-1:0] in_data       [0:FFT_POINTS-1],
    output logic [OUT_WIDTH-1:0]  out_data_real [0:FFT_POINTS-1],
    output logic [OUT_WIDTH-1:0]  out_data_imag [0:FFT_POINTS-1],
    output logic                  fft_data_valid,
    output logic                  fft_in_prog
);

    // product width: OUT_WIDTH x 16-bit twiddle
    localparam int PW = OUT_WIDTH + 16;

    // Q1.15 magnitudes of cos/sin at 22.5, 45 and 67.5 degrees
    localparam logic signed [15:0] K1 = 16'sd30274;
    localparam logic signed [15:0] K2 = 16'sd23170;
    localparam logic signed [15:0] K3 = 16'sd12540;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t state;

    // counts remaining butterflies down to zero; 31 at the first butterfly
    logic [4:0] bf_cnt;

    logic signed [OUT_WIDTH-1:0] buf_re [0:FFT_POINTS-1];
    logic signed [OUT_WIDTH-1:0] buf_im [0:FFT_POINTS-1];

    logic [4:0] bf_idx;
    logic [1:0] stage;
    logic [2:0] bf;
    logic [3:0] a_idx;
    logic [3:0] b_idx;
    logic [2:0] tw_m;

    logic signed [15:0] w_re;
    logic signed [15:0] w_im;

    logic signed [OUT_WIDTH-1:0] a_re;
    logic signed [OUT_WIDTH-1:0] a_im;
    logic signed [OUT_WIDTH-1:0] b_re;
    logic signed [OUT_WIDTH-1:0] b_im;
    logic signed [OUT_WIDTH-1:0] t_re;
    logic signed [OUT_WIDTH-1:0] t_im;

    logic signed [PW-1:0] prod_rr;
    logic signed [PW-1:0] prod_ii;
    logic signed [PW-1:0] prod_ri;
    logic signed [PW-1:0] prod_ir;
    logic signed [PW-1:0] sum_r;
    logic signed [PW-1:0] sum_i;

    function automatic logic [3:0] bit_rev(input logic [3:0] i);
        return {i[0], i[1], i[2], i[3]};
    endfunction

    function automatic logic [OUT_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] d);
        return {{(OUT_WIDTH-DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
    endfunction

    assign bf_idx = 5'd31 - bf_cnt;
    assign stage  = bf_idx[4:3];
    assign bf     = bf_idx[2:0];

    // butterfly operand addresses and twiddle exponent for (stage, butterfly)
    always_comb begin
        a_idx = {bf, 1'b0};
        b_idx = {bf, 1'b1};
        tw_m  = 3'd0;
        case (stage)
            2'd0: begin
                a_idx = {bf, 1'b0};
                b_idx = {bf, 1'b1};
                tw_m  = 3'd0;
            end
            2'd1: begin
                a_idx = {bf[2:1], 1'b0, bf[0]};
                b_idx = {bf[2:1], 1'b1, bf[0]};
                tw_m  = {bf[0], 2'b00};
            end
            2'd2: begin
                a_idx = {bf[2], 1'b0, bf[1:0]};
                b_idx = {bf[2], 1'b1, bf[1:0]};
                tw_m  = {bf[1:0], 1'b0};
            end
            default: begin
                a_idx = {1'b0, bf};
                b_idx = {1'b1, bf};
                tw_m  = bf;
            end
        endcase
    end

    // W16^m = cos - j*sin; m=0 and m=4 never reach the multiplier
    always_comb begin
        w_re = 16'sd0;
        w_im = 16'sd0;
        case (tw_m)
            3'd1: begin w_re =  K1; w_im = -K3; end
            3'd2: begin w_re =  K2; w_im = -K2; end
            3'd3: begin w_re =  K3; w_im = -K1; end
            3'd5: begin w_re = -K3; w_im = -K1; end
            3'd6: begin w_re = -K2; w_im = -K2; end
            3'd7: begin w_re = -K1; w_im = -K3; end
            default: begin w_re = 16'sd0; w_im = 16'sd0; end
        endcase
    end

    assign a_re = buf_re[a_idx];
    assign a_im = buf_im[a_idx];
    assign b_re = buf_re[b_idx];
    assign b_im = buf_im[b_idx];

    assign prod_rr = PW'(b_re) * PW'(w_re);
    assign prod_ii = PW'(b_im) * PW'(w_im);
    assign prod_ri = PW'(b_re) * PW'(w_im);
    assign prod_ir = PW'(b_im) * PW'(w_re);
    assign sum_r   = prod_rr - prod_ii;
    assign sum_i   = prod_ri + prod_ir;

    // t = W*B; trivial twiddles are exact, the rest truncate toward -inf
    always_comb begin
        t_re = b_re;
        t_im = b_im;
        case (tw_m)
            3'd0: begin
                t_re = b_re;
                t_im = b_im;
            end
            3'd4: begin
                t_re = b_im;
                t_im = -b_re;
            end
            default: begin
                t_re = OUT_WIDTH'(sum_r >>> 15);
                t_im = OUT_WIDTH'(sum_i >>> 15);
            end
        endcase
    end

    // sequencer: load on start, one butterfly per clock, then publish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bf_cnt         <= 5'd0;
            fft_data_valid <= 1'b0;
            fft_in_prog    <= 1'b0;
            for (int i = 0; i < FFT_POINTS; i++) begin
                buf_re[i]        <= '0;
                buf_im[i]        <= '0;
                out_data_real[i] <= '0;
                out_data_imag[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_fft) begin
                        for (int i = 0; i < FFT_POINTS; i++) begin
                            buf_re[i] <= sext(in_data[bit_rev(4'(i))]);
                            buf_im[i] <= '0;
                        end
                        bf_cnt         <= 5'd31;
                        fft_in_prog    <= 1'b1;
                        fft_data_valid <= 1'b0;
                        state          <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    buf_re[a_idx] <= a_re + t_re;
                    buf_im[a_idx] <= a_im + t_im;
                    buf_re[b_idx] <= a_re - t_re;
                    buf_im[b_idx] <= a_im - t_im;
                    if (bf_cnt == 5'd0) begin
                        state <= DONE;
                    end else begin
                        bf_cnt <= bf_cnt - 5'd1;
                    end
                end
                DONE: begin
                    for (int i = 0; i < FFT_POINTS; i++) begin
                        out_data_real[i] <= buf_re[i];
                        out_data_imag[i] <= buf_im[i];
                    end
                    fft_data_valid <= 1'b1;
                    fft_in_prog    <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_controller.sv
// Bench for fft_controller: directed vectors, a transaction-level FFT model and
// a per-cycle compare of all outputs, plus hand-computed literal bin values.
module tb_fft_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_fft;
    logic [23:0] in_data       [0:15];
    logic [31:0] out_data_real [0:15];
    logic [31:0] out_data_imag [0:15];
    logic        fft_data_valid;
    logic        fft_in_prog;

    int checks   = 0;
    int failures = 0;

    fft_controller #(
        .FFT_POINTS(16),
        .DATA_WIDTH(24),
        .OUT_WIDTH (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_fft     (start_fft),
        .in_data       (in_data),
        .out_data_real (out_data_real),
        .out_data_imag (out_data_imag),
        .fft_data_valid(fft_data_valid),
        .fft_in_prog   (fft_in_prog)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_near0(input string name, input logic [31:0] act);
        int d;
        d = $signed(act);
        checks++;
        if (d < -4 || d > 4) begin
            failures++;
            $display("FAIL %s actual=%h required=0+/-4", name, act);
        end
    endtask

    // ---------------- reference model ----------------
    int     mag [0:4] = '{32768, 30274, 23170, 12540, 0};
    longint mr  [0:15];
    longint mi  [0:15];

    bit          m_busy  = 1'b0;
    int          m_cnt   = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_out_re  [0:15];
    logic [31:0] m_out_im  [0:15];
    logic [31:0] m_pend_re [0:15];
    logic [31:0] m_pend_im [0:15];

    function automatic longint w32(input longint v);
        logic [31:0] t;
        t = v[31:0];
        return longint'($signed(t));
    endfunction

    function automatic int rev4(input int n);
        return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
    endfunction

    function automatic longint tw_cos(input int m);
        if (m <= 4) return longint'(mag[m]);
        return -longint'(mag[8 - m]);
    endfunction

    function automatic longint tw_sin(input int m);
        if (m <= 4) return longint'(mag[4 - m]);
        return longint'(mag[m - 4]);
    endfunction

    // textbook in-place DIT FFT with quantised twiddles and 32-bit wrap
    task automatic compute_ref();
        longint wr, wi, tr, ti, ar, ai;
        int h, m, a, b;
        for (int n = 0; n < 16; n++) begin
            mr[rev4(n)] = longint'($signed(in_data[n]));
            mi[rev4(n)] = 0;
        end
        for (int s = 0; s < 4; s++) begin
            h = 1 << s;
            for (int g = 0; g < 16; g += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    m  = j * (8 >> s);
                    a  = g + j;
                    b  = a + h;
                    wr = tw_cos(m);
                    wi = -tw_sin(m);
                    tr = w32((mr[b] * wr - mi[b] * wi) >>> 15);
                    ti = w32((mr[b] * wi + mi[b] * wr) >>> 15);
                    ar = mr[a];
                    ai = mi[a];
                    mr[a] = w32(ar + tr);
                    mi[a] = w32(ai + ti);
                    mr[b] = w32(ar - tr);
                    mi[b] = w32(ai - ti);
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            m_pend_re[k] = mr[k][31:0];
            m_pend_im[k] = mi[k][31:0];
        end
    endtask

    // transaction model: capture at accepted start, publish 33 clocks later
    always @(posedge clk) begin
        if (reset) begin
            m_busy  = 1'b0;
            m_cnt   = 0;
            m_valid = 1'b0;
            for (int k = 0; k < 16; k++) begin
                m_out_re[k] = '0;
                m_out_im[k] = '0;
            end
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == 33) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
                for (int k = 0; k < 16; k++) begin
                    m_out_re[k] = m_pend_re[k];
                    m_out_im[k] = m_pend_im[k];
                end
            end
        end else if (start_fft) begin
            compute_ref();
            m_busy  = 1'b1;
            m_cnt   = 0;
            m_valid = 1'b0;
        end
    end

    // per-cycle compare of every output against the model
    always @(posedge clk) begin
        #1;
        chk("in_prog", 32'(fft_in_prog), 32'(m_busy));
        chk("valid", 32'(fft_data_valid), 32'(m_valid));
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("re[%0d]", k), out_data_real[k], m_out_re[k]);
            chk($sformatf("im[%0d]", k), out_data_imag[k], m_out_im[k]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_once(input string name);
        int edges;
        int prog;
        @(negedge clk);
        start_fft = 1'b1;
        @(negedge clk);
        start_fft = 1'b0;
        edges = 1;
        prog  = fft_in_prog ? 1 : 0;
        while (!fft_data_valid && edges < 100) begin
            @(negedge clk);
            edges++;
            if (fft_in_prog) prog++;
        end
        chk({name, "_valid_reached"}, 32'(fft_data_valid), 32'd1);
        chk({name, "_latency"}, 32'(edges - 1), 32'd33);
        chk({name, "_prog_cycles"}, 32'(prog), 32'd33);
    endtask

    task automatic check_impulse(input string name);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_re[%0d]", name, k), out_data_real[k], 32'h00400000);
            chk($sformatf("%s_im[%0d]", name, k), out_data_imag[k], 32'h0);
        end
    endtask

    initial begin
        int vcnt;
        int pcnt;
        int bound;
        reset     = 1'b1;
        start_fft = 1'b0;
        for (int n = 0; n < 16; n++) in_data[n] = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(fft_data_valid), 32'd0);
        chk("rst_prog", 32'(fft_in_prog), 32'd0);
        chk("rst_re0", out_data_real[0], 32'h0);
        chk("rst_im15", out_data_imag[15], 32'h0);
        reset = 1'b0;

        // impulse
        @(negedge clk);
        for (int n = 0; n < 16; n++) in_data[n] = '0;
        in_data[0] = 24'h400000;
        run_once("impulse");
        check_impulse("impulse");

        // period-4 square wave
        for (int n = 0; n < 16; n++) in_data[n] = ((n % 4) < 2) ? 24'h400000 : 24'hC00000;
        run_once("square");
        for (int k = 0; k < 16; k++) begin
            if (k == 4) begin
                chk("sq_re4", out_data_real[4], 32'h02000000);
                chk("sq_im4", out_data_imag[4], 32'hFE000000);
            end else if (k == 12) begin
                chk("sq_re12", out_data_real[12], 32'h02000000);
                chk("sq_im12", out_data_imag[12], 32'h02000000);
            end else begin
                chk_near0($sformatf("sq_re[%0d]", k), out_data_real[k]);
                chk_near0($sformatf("sq_im[%0d]", k), out_data_imag[k]);
            end
        end

        // DC at positive full scale
        for (int n = 0; n < 16; n++) in_data[n] = 24'h7FFFFF;
        run_once("dc");
        chk("dc_re0", out_data_real[0], 32'h07FFFFF0);
        chk("dc_im0", out_data_imag[0], 32'h0);
        for (int k = 1; k < 16; k++) begin
            chk_near0($sformatf("dc_re[%0d]", k), out_data_real[k]);
            chk_near0($sformatf("dc_im[%0d]", k), out_data_imag[k]);
        end

        // mixed-sign vector with both full-scale extremes (model-checked)
        for (int n = 0; n < 16; n++) in_data[n] = 24'(n * 24'h0A1B2C) ^ 24'h5A5A5A;
        in_data[3] = 24'h800000;
        in_data[7] = 24'h7FFFFF;
        in_data[12] = 24'hFFFFFF;
        run_once("mixed");

        // ramp, with in_data scrambled while the transform runs
        for (int n = 0; n < 16; n++) in_data[n] = 24'(n << 16);
        @(negedge clk);
        start_fft = 1'b1;
        @(negedge clk);
        start_fft = 1'b0;
        repeat (5) @(negedge clk);
        for (int n = 0; n < 16; n++) in_data[n] = 24'h800001 + 24'(n * 3);
        bound = 0;
        while (!fft_data_valid && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        chk("ramp_valid_reached", 32'(fft_data_valid), 32'd1);
        chk("ramp_re0", out_data_real[0], 32'h00780000);
        chk("ramp_im0", out_data_imag[0], 32'h0);
        chk("ramp_re8", out_data_real[8], 32'hFFF80000);
        chk("ramp_im8", out_data_imag[8], 32'h0);

        // start held high for 40 cycles: back-to-back runs
        for (int n = 0; n < 16; n++) in_data[n] = 24'(n * 24'h031415) - 24'h123456;
        @(negedge clk);
        start_fft = 1'b1;
        vcnt = 0;
        pcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fft_data_valid) vcnt++;
            if (fft_in_prog) pcnt++;
        end
        start_fft = 1'b0;
        chk("b2b_valid_cycles", 32'(vcnt), 32'd1);
        chk("b2b_prog_cycles", 32'(pcnt), 32'd39);
        bound = 0;
        while (!fft_data_valid && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        chk("b2b_second_valid", 32'(fft_data_valid), 32'd1);

        // reset in the middle of a run
        for (int n = 0; n < 16; n++) in_data[n] = 24'h3F0F0F - 24'(n * 24'h011111);
        @(negedge clk);
        start_fft = 1'b1;
        @(negedge clk);
        start_fft = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_valid", 32'(fft_data_valid), 32'd0);
        chk("abort_prog", 32'(fft_in_prog), 32'd0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("abort_re[%0d]", k), out_data_real[k], 32'h0);
            chk($sformatf("abort_im[%0d]", k), out_data_imag[k], 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fft_data_valid) vcnt++;
        end
        chk("abort_no_valid", 32'(vcnt), 32'd0);
        for (int n = 0; n < 16; n++) in_data[n] = '0;
        in_data[0] = 24'h400000;
        run_once("post_abort");
        check_impulse("post_abort");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_controller.md
FFT_CONTROLLER -- requirements
Module: fft_controller

Interface
REQ-001 SHALL have parameter FFT_POINTS, default 16: transform length (only supported value).
REQ-002 SHALL have parameter DATA_WIDTH, default 24: input sample width, signed two's complement.
REQ-003 SHALL have parameter OUT_WIDTH, default 32: output and internal datapath width, signed.
REQ-004 SHALL have a single clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start_fft  input  1  request to start a transform; level, sampled in IDLE.
REQ-008 in_data  input  [23:0] x [0:15] unpacked  time-domain real samples, index n in natural order.
REQ-009 out_data_real  output  [31:0] x [0:15] unpacked  Re X[k], natural order.
REQ-010 out_data_imag  output  [31:0] x [0:15] unpacked  Im X[k], natural order.
REQ-011 fft_data_valid  output  1  outputs hold a completed transform.
REQ-012 fft_in_prog  output  1  transform running.

Function
REQ-013 SHALL compute the unscaled DFT X[k] = sum over n of x[n]*exp(-j*2*pi*k*n/16); real input, imaginary input treated as 0.
REQ-014 SHALL use iterative radix-2 decimation-in-time with an internal 16-entry complex register array (32-bit re/im): 4 stages x 8 butterflies, one butterfly per clock.
REQ-015 SHALL use states IDLE, COMPUTE and DONE.
REQ-016 In IDLE with start_fft=1 at a rising edge (edge E0), SHALL load in_data sign-extended to 32 bits into the array in bit-reversed order with imag=0, set fft_in_prog=1, clear fft_data_valid, and enter COMPUTE.
REQ-017 COMPUTE SHALL execute butterflies on edges E1..E32, stage s=0..3 outer and butterfly b=0..7 inner, span 2^s, twiddle W16^(b mod 2^s * 2^(3-s)).
REQ-018 Butterfly: t=W*B; A'=A+t; B'=A-t; 32-bit wrap-around arithmetic, no scaling.
REQ-019 Twiddle W16^m = cos(2*pi*m/16) - j*sin(2*pi*m/16), m=0..7, stored as signed 16-bit Q1.15 rounded to nearest: cos/sin magnitudes 30274, 23170, 12540, 0.
REQ-020 m=0 SHALL bypass the multiplier (t=B exactly); m=4 (-j) SHALL be realised exactly as a swap/negate.
REQ-021 Complex product terms SHALL be full-precision (48-bit) sums, arithmetic-shifted right 15 bits (truncation toward minus infinity) to 32 bits.
REQ-022 At edge E33 (DONE), SHALL copy the array to out_data_real/out_data_imag in natural order, set fft_data_valid=1, clear fft_in_prog, and return to IDLE.
REQ-023 Outputs and fft_data_valid SHALL hold until the next accepted start, when fft_data_valid clears and outputs keep their old values until E33 of the new run.
REQ-024 start_fft SHALL be ignored in COMPUTE and DONE; if still high in IDLE after completion, a new run SHALL begin.
REQ-025 Latency: E0 to fft_data_valid=1 is 33 clocks; fft_in_prog is high for exactly 33 cycles.
REQ-026 in_data SHALL be sampled only at E0; later changes SHALL not affect the result.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, fft_data_valid=0, fft_in_prog=0, all out_data_real/out_data_imag=0, and the internal array to 0.
REQ-028 reset asserted mid-transform SHALL abort the run; no valid SHALL be produced for it.

Verification
REQ-029 x[n]=0x400000 if n mod 4 < 2, else 0xC00000; pulse start -> after 33 clocks valid=1; X[4]=0x02000000 - j0x02000000 (imag 0xFE000000); X[12]=0x02000000 + j0x02000000; all other bins within +/-4 LSB of 0.
REQ-030 Impulse x[0]=0x400000, others 0 -> every bin real=0x00400000, imag=0 exactly.
REQ-031 DC: all x[n]=0x7FFFFF -> X[0]=0x07FFFFF0, imag 0; other bins within +/-4 LSB of 0.
REQ-032 Hold start_fft high for 40 cycles -> fft_in_prog high for E0..E32; valid at E33; a second run starts at the following edge, clearing valid.
REQ-033 Assert reset at E10 of a run -> all outputs 0 immediately; no valid pulse; a subsequent start completes normally in 33 clocks.
REQ-034 Change in_data during COMPUTE -> result equals transform of the samples captured at E0.
